fpu_serial_harness: RTL and testbench

//  Parametrised serial-line command controller for FPU device tests; successor of the fixed 1+8-byte cmp test FSM.

---
 rtl/fpu_test_pkg.sv | 25 ++
 rtl/fpu_serial_harness_if.sv | 34 +++
 rtl/fpu_harness_timer.sv | 21 ++
 rtl/fpu_serial_harness.sv | 139 +++++++++++++
 tb/tb_fpu_serial_harness.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fpu_test_pkg.sv
// Shared definitions for FPU device-test harnesses: FSM state encodings,
// exception flag bit positions and op-byte fields.
package fpu_test_pkg;

  localparam logic [2:0] S_OP   = 3'd0;
  localparam logic [2:0] S_RCV  = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_XRES = 3'd3;
  localparam logic [2:0] S_XFLG = 3'd4;
  localparam logic [2:0] S_XCHK = 3'd5;

  // flag byte layout, LSB first: NX UF OF DZ NV
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  // op byte: low bits select unit function/predicate, high bits rounding mode
  localparam int OP_FUNC_LSB = 0;
  localparam int OP_FUNC_W   = 5;
  localparam int OP_RM_LSB   = 5;
  localparam int OP_RM_W     = 3;

endpackage

// File: rtl/fpu_serial_harness_if.sv
// Byte-link and FP-unit signal bundle for fpu_serial_harness.
// master = harness side, slave = receiver/transmitter/unit side.
interface fpu_serial_harness_if #(
  parameter int WORD_BYTES = 4,
  parameter int NUM_OPS    = 2,
  parameter int RES_BYTES  = 4,
  parameter int FLAG_BITS  = 5
);
  localparam int W  = 8 * WORD_BYTES;
  localparam int RW = 8 * RES_BYTES;

  logic                   rcv_rdy;
  logic [7:0]             rcv_data;
  logic                   rcv_read;
  logic                   xmt_rdy;
  logic                   xmt_wrt;
  logic [7:0]             xmt_data;
  logic [7:0]             op;
  logic [NUM_OPS*W-1:0]   opnd;
  logic                   run;
  logic                   stall;
  logic [RW-1:0]          res_in;
  logic [FLAG_BITS-1:0]   flags_in;

  modport master (
    input  rcv_rdy, rcv_data, xmt_rdy, stall, res_in, flags_in,
    output rcv_read, xmt_wrt, xmt_data, op, opnd, run
  );

  modport slave (
    output rcv_rdy, rcv_data, xmt_rdy, stall, res_in, flags_in,
    input  rcv_read, xmt_wrt, xmt_data, op, opnd, run
  );
endinterface

// File: rtl/fpu_harness_timer.sv
// Loadable down-counter; expired pulses while enabled at zero and not loading.
module fpu_harness_timer #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expired
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                    cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = en & ~load & (cnt == '0);
endmodule

// File: rtl/fpu_serial_harness.sv
// Serial command controller for FPU device tests: op byte + operands in,
// result bytes + flag byte out. Define FPU_HARNESS_CSUM_EN to append an XOR checksum byte.
module fpu_serial_harness
  import fpu_test_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int NUM_OPS    = 2,
  parameter int RES_BYTES  = 4,
  parameter int FLAG_BITS  = 5,
  parameter int TIMEOUT    = 500000
) (
  input  logic                 clk,
  input  logic                 rst,
  fpu_serial_harness_if.master bus
);
  localparam int NB   = NUM_OPS * WORD_BYTES;
  localparam int CMAX = (NB > RES_BYTES) ? NB : RES_BYTES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TV   = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [2:0]                 state;
  logic [CW-1:0]              cnt;
  logic [7:0]                 op_q;
  logic [NB-1:0][7:0]         opnd_q;
  logic [RES_BYTES-1:0][7:0]  res_q;
  logic [FLAG_BITS-1:0]       flg_q;
  logic [7:0]                 flag_byte;
  logic [7:0]                 xd;
  logic                       pop, push, run_c;
  logic                       tmr_exp, tmo;
`ifdef FPU_HARNESS_CSUM_EN
  logic [7:0]                 csum;
`endif

  always_comb begin
    flag_byte = '0;
    flag_byte[FLAG_BITS-1:0] = flg_q;
  end

`ifdef FPU_HARNESS_CSUM_EN
  always_comb begin
    csum = flag_byte;
    for (int i = 0; i < RES_BYTES; i++) csum = csum ^ res_q[i];
  end
`endif

  // Strobes are gated by rst so nothing leaks out while reset is held.
  always_comb begin
    pop   = 1'b0;
    push  = 1'b0;
    run_c = 1'b0;
    xd    = '0;
    case (state)
      S_OP, S_RCV: pop = bus.rcv_rdy & ~rst;
      S_EXEC:      run_c = ~rst;
      S_XRES: begin
        for (int i = 0; i < RES_BYTES; i++)
          if (cnt == CW'(i)) xd = res_q[i];
        push = bus.xmt_rdy & ~rst;
      end
      S_XFLG: begin
        xd   = flag_byte;
        push = bus.xmt_rdy & ~rst;
      end
`ifdef FPU_HARNESS_CSUM_EN
      S_XCHK: begin
        xd   = csum;
        push = bus.xmt_rdy & ~rst;
      end
`endif
      default: ;
    endcase
  end

  // Idle-gap watchdog: reloaded outside S_RCV and on every pop.
  fpu_harness_timer #(.WIDTH(TW)) u_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     ((state != S_RCV) | pop),
    .load_val (TW'(TV)),
    .en       ((state == S_RCV) & ~bus.rcv_rdy),
    .expired  (tmr_exp)
  );
  assign tmo = (TIMEOUT != 0) && tmr_exp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_OP;
      cnt    <= '0;
      op_q   <= '0;
      opnd_q <= '0;
      res_q  <= '0;
      flg_q  <= '0;
    end else begin
      case (state)
        S_OP: if (pop) begin
          op_q  <= bus.rcv_data;
          cnt   <= '0;
          state <= S_RCV;
        end
        S_RCV: begin
          if (pop) begin
            for (int i = 0; i < NB; i++)
              if (cnt == CW'(i)) opnd_q[i] <= bus.rcv_data;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(NB - 1)) state <= S_EXEC;
          end else if (tmo) begin
            state <= S_OP;
          end
        end
        S_EXEC: if (!bus.stall) begin
          res_q <= bus.res_in;
          flg_q <= bus.flags_in;
          cnt   <= '0;
          state <= S_XRES;
        end
        S_XRES: if (push) begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(RES_BYTES - 1)) state <= S_XFLG;
        end
`ifdef FPU_HARNESS_CSUM_EN
        S_XFLG: if (push) state <= S_XCHK;
        S_XCHK: if (push) state <= S_OP;
`else
        S_XFLG: if (push) state <= S_OP;
`endif
        default: state <= S_OP;
      endcase
    end
  end

  assign bus.rcv_read = pop;
  assign bus.xmt_wrt  = push;
  assign bus.xmt_data = xd;
  assign bus.op       = op_q;
  assign bus.opnd     = opnd_q;
  assign bus.run      = run_c;
endmodule

// File: tb/tb_fpu_serial_harness.sv
// Table-driven bench for fpu_serial_harness with a response-byte scoreboard.
module tb_fpu_serial_harness;
  import fpu_test_pkg::*;

  localparam int TMO = 1500;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fpu_serial_harness_if #(.WORD_BYTES(4), .NUM_OPS(2), .RES_BYTES(4), .FLAG_BITS(5)) bus ();

  fpu_serial_harness #(.WORD_BYTES(4), .NUM_OPS(2), .RES_BYTES(4), .FLAG_BITS(5), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    logic [7:0]  op;
    logic [63:0] ob;     // operand bytes, byte i sent i-th; equals expected opnd
    logic [31:0] res;
    logic [4:0]  flg;
    int          stall_n;
    int          gap;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] exp_q[$];
  int nchk = 0, npass = 0, nwr = 0, npops = 0, nsent = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act === expv) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  // Transmit/receive side monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.rcv_read) begin
      npops++;
      if (!bus.rcv_rdy) chk("rcv_read_without_rdy", bus.rcv_read, 0);
    end
    if (bus.xmt_wrt) begin
      nwr++;
      if (!bus.xmt_rdy) chk("xmt_wrt_without_rdy", bus.xmt_wrt, 0);
      if (exp_q.size() == 0) begin
        nchk++;
        $display("FAIL unexpected_byte: got %h expected none", bus.xmt_data);
      end else begin
        chk("resp_byte", bus.xmt_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", npass, nchk);
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got = 0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.rcv_rdy = 1'b1; bus.rcv_data = b;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk); if (bus.rcv_read) got = 1;
      @(posedge clk); #1;
    end
    bus.rcv_rdy = 1'b0;
    nsent++;
    if (!got) begin nchk++; $display("FAIL pop_timeout: byte %h not popped", b); end
  endtask

  task automatic do_reset_check(input string tag);
    bus.rcv_rdy = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_rcv_read"}, bus.rcv_read, 0);
    chk({tag, "_xmt_wrt"},  bus.xmt_wrt, 0);
    chk({tag, "_run"},      bus.run, 0);
    chk({tag, "_op"},       bus.op, 0);
    chk({tag, "_opnd"},     bus.opnd, 0);
    chk({tag, "_xmt_data"}, bus.xmt_data, 0);
    rst = 1'b0;
    repeat (50) begin @(posedge clk); #1; end
  endtask

  task automatic run_cmd(input vec_t v, input int hold_after, input int rst_after);
    logic [7:0] cs;
    int base, w0;
    cs = {3'b0, v.flg};
    for (int i = 0; i < 4; i++) begin exp_q.push_back(v.res[i*8 +: 8]); cs ^= v.res[i*8 +: 8]; end
    exp_q.push_back({3'b0, v.flg});
`ifdef FPU_HARNESS_CSUM_EN
    exp_q.push_back(cs);
`endif
    bus.stall = 1'b1; bus.res_in = v.res; bus.flags_in = v.flg;
    send_byte(v.op, v.gap);
    for (int i = 0; i < 8; i++) send_byte(v.ob[i*8 +: 8], v.gap);
    chk("run_latency", bus.run, 1);
    chk("op", bus.op, v.op);
    chk("opnd", bus.opnd, v.ob);
    repeat (v.stall_n) begin @(posedge clk); #1; end
    if (v.stall_n > 0) chk("run_held_in_stall", bus.run, 1);
    bus.stall = 1'b0;
    @(posedge clk); #1;
    bus.stall = 1'b1;
    chk("first_wrt_latency", bus.xmt_wrt, 1);
    chk("run_off_after_capture", bus.run, 0);
    base = nwr;
    for (int t = 0; t < 600 && exp_q.size() > 0; t++) begin
      if (hold_after >= 0 && nwr - base == hold_after) begin
        bus.xmt_rdy = 1'b0; w0 = nwr;
        repeat (200) begin @(posedge clk); #1; end
        chk("hold_no_wrt", 64'(nwr - w0), 0);
        bus.xmt_rdy = 1'b1; hold_after = -1;
      end
      if (rst_after >= 0 && nwr - base == rst_after) begin
        exp_q.delete();
        do_reset_check("rst_xres");
        break;
      end
      @(posedge clk); #1;
    end
    chk("response_drained", 64'(exp_q.size()), 0);
  endtask

  initial begin
    vecs[0] = '{8'h03, 64'h40000000_3F800000, 32'h00000001, 5'h00, 3, 0};
    vecs[1] = '{8'hA5, 64'hC0490FDB_7F800000, 32'hFFFFFFFF, 5'h1F, 0, 1};
    vecs[2] = '{8'h10, 64'h00000000_00000000, 32'h00000000, 5'h10, 7, 3};
    vecs[3] = '{8'h42, 64'h12345678_9ABCDEF0, 32'h12345678, 5'h11, 1, 0};
    vecs[4] = '{8'hFF, 64'h80000001_FFFFFFFE, 32'h80000000, 5'h01, 2, 1000};

    bus.rcv_rdy = 1'b0; bus.rcv_data = '0; bus.xmt_rdy = 1'b1;
    bus.stall = 1'b1; bus.res_in = '0; bus.flags_in = '0;
    repeat (3) @(posedge clk); #1;
    chk("reset_rcv_read", bus.rcv_read, 0);
    chk("reset_xmt_wrt",  bus.xmt_wrt, 0);
    chk("reset_run",      bus.run, 0);
    chk("reset_op",       bus.op, 0);
    chk("reset_opnd",     bus.opnd, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_cmd(vecs[i], -1, -1);

    // xmt_rdy low for 200 cycles after two response bytes
    run_cmd(vecs[3], 2, -1);

    // timeout after op + 3 operand bytes
    send_byte(8'h77, 0);
    for (int i = 0; i < 3; i++) send_byte(8'hA0 + 8'(i), 0);
    repeat (TMO - 1) begin @(posedge clk); #1; end
    chk("timeout_not_yet", dut.state, S_RCV);
    @(posedge clk); #1;
    chk("timeout_abort", dut.state, S_OP);
    chk("timeout_no_run", bus.run, 0);
    run_cmd(vecs[1], -1, -1);

    // reset mid-command, then reset mid-response
    send_byte(8'h05, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    do_reset_check("rst_rcv");
    run_cmd(vecs[0], -1, -1);
    run_cmd(vecs[3], -1, 2);
    run_cmd(vecs[2], -1, -1);

    repeat (20) begin @(posedge clk); #1; end
    chk("pops_equal_sent", 64'(npops), 64'(nsent));
    chk("scoreboard_empty", 64'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
